// File: rtl/jtframe_ram.sv
// Single-port synchronous RAM with clock enable.
// Read data appears one enabled tick after the address is presented.
module jtframe_ram #(
    parameter int aw = 9,
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          cen,
    input  logic [dw-1:0] data,
    input  logic [aw-1:0] addr,
    input  logic          we,
    output logic [dw-1:0] q
);

    localparam int DEPTH = 1 << aw;

    logic [dw-1:0] mem_r [0:DEPTH-1];

    // Storage write and registered read; a same-tick read returns the old byte
    always_ff @(posedge clk) begin
        if (cen) begin
            if (we) begin
                mem_r[addr] <= data;
            end
            q <= mem_r[addr];
        end
    end

endmodule

// File: rtl/jtdd_shared_arb.sv
// Arbiter for the 512-byte RAM shared by the main CPU and the 63701 MCU.
// Halts the MCU, gives the CPU one RAM slot, then holds the halt for a few ticks.
module jtdd_shared_arb #(
    parameter int AW      = 9,
    parameter int HALT_TO = 15,
    parameter int HOLD    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen6,
    input  logic          cpu_cs,
    input  logic          cpu_wrn,
    input  logic [AW-1:0] cpu_AB,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    cpu_din,
    output logic          cpu_wait,
    input  logic          main_haltn,
    output logic          mcu_haltn,
    input  logic          mcu_ba,
    input  logic          mcu_cs,
    input  logic          mcu_wr,
    input  logic [AW-1:0] mcu_AB,
    input  logic [7:0]    mcu_dout,
    output logic [7:0]    mcu_din,
    output logic          to_err
);

    localparam int CNT_MAX = (HALT_TO > HOLD) ? HALT_TO : HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_MAX_C = CW'(CNT_MAX);
    localparam logic [CW-1:0] HALT_TO_C = CW'(HALT_TO);
    localparam logic [CW-1:0] HOLD_C    = CW'(HOLD);
    localparam logic [CW-1:0] ONE_C     = CW'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HALT   = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    logic [2:0]    state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_inc_s, cnt_dec_s;
    logic          served_r, to_err_r;
    logic [7:0]    cpu_din_r;
    logic          new_req_s, arb_haltn_s;
    logic [AW-1:0] ram_addr_s;
    logic [7:0]    ram_data_s, ram_q_s;
    logic          ram_we_s;

    assign new_req_s = cpu_cs & ~served_r;
    assign cnt_inc_s = (cnt_r == CNT_MAX_C) ? cnt_r : cnt_r + ONE_C;
    assign cnt_dec_s = (cnt_r == '0) ? cnt_r : cnt_r - ONE_C;

    assign cpu_wait  = cpu_cs & ~served_r;
    assign mcu_haltn = main_haltn & arb_haltn_s;
    assign mcu_din   = ram_q_s;
    assign cpu_din   = cpu_din_r;
    assign to_err    = to_err_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode, advancing only on cen6 ticks
    always_comb begin
        state_s = state_r;
        if (cen6) begin
            case (state_r)
                ST_IDLE:   if (new_req_s) state_s = ST_HALT; else state_s = ST_IDLE;
                ST_HALT:   if (mcu_ba || cnt_inc_s == HALT_TO_C) state_s = ST_ACCESS;
                           else state_s = ST_HALT;
                ST_ACCESS: state_s = ST_DONE;
                ST_DONE:   state_s = ST_HOLD;
                ST_HOLD:   if (new_req_s) state_s = ST_ACCESS;
                           else if (cnt_dec_s == '0) state_s = ST_IDLE;
                           else state_s = ST_HOLD;
                default:   state_s = ST_IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Halt request and RAM port ownership; the MCU never writes while the CPU owns the port
    always_comb begin
        arb_haltn_s = 1'b1;
        ram_addr_s  = mcu_AB;
        ram_data_s  = mcu_dout;
        ram_we_s    = mcu_wr & mcu_cs & ~mcu_ba;
        case (state_r)
            ST_IDLE:   arb_haltn_s = 1'b1;
            ST_ACCESS: begin
                arb_haltn_s = 1'b0;
                ram_addr_s  = cpu_AB;
                ram_data_s  = cpu_dout;
                ram_we_s    = ~cpu_wrn;
            end
            ST_HALT, ST_DONE, ST_HOLD: arb_haltn_s = 1'b0;
            default:   arb_haltn_s = 1'b1;
        endcase
    end

    // Timeout/hold counter, served flag, sticky timeout flag and CPU read latch
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            served_r  <= 1'b0;
            to_err_r  <= 1'b0;
            cpu_din_r <= 8'h00;
        end else begin
            if (!cpu_cs) begin
                served_r <= 1'b0;
            end
            if (cen6) begin
                case (state_r)
                    ST_IDLE: if (new_req_s) cnt_r <= '0;
                    ST_HALT: begin
                        if (!mcu_ba) begin
                            cnt_r <= cnt_inc_s;
                            if (cnt_inc_s == HALT_TO_C) to_err_r <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        cpu_din_r <= ram_q_s;
                        served_r  <= 1'b1;
                        cnt_r     <= HOLD_C;
                    end
                    ST_HOLD: if (!new_req_s) cnt_r <= cnt_dec_s;
                    default: ;
                endcase
            end
        end
    end

    jtframe_ram #(.aw(AW), .dw(8)) u_ram (
        .clk  (clk),
        .cen  (cen6),
        .data (ram_data_s),
        .addr (ram_addr_s),
        .we   (ram_we_s),
        .q    (ram_q_s)
    );

endmodule
